serial_magnitude_comparator: RTL and testbench

//   Multi-cycle magnitude comparator for two WIDTH-bit operands.
//   - Processes CHUNK bits per clock, MSB chunk first.
//   - Reports eq/lt/gt and terminates early on the first differing chunk.
//   - Supports unsigned and two's-complement compare, selected per operation.
//   - Generalises the combinational 5-bit equality comparator for datapaths

---
 rtl/serial_magnitude_comparator.sv | 142 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock,
// MSB chunk first, and stops on the first chunk that differs. Supports
// unsigned and two's-complement compare, selected per operation.
module serial_magnitude_comparator #(
   parameter int WIDTH     = 8,
   parameter int CHUNK     = 1,
   parameter int SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IW    = (N > 1) ? $clog2(N) : 1;
   localparam int SLOTS = 2 ** IW;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             mode_reg;
   logic [IW-1:0]    idx_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             eq_reg;
   logic             lt_reg;
   logic             gt_reg;

   logic [WIDTH-1:0] a_cmp;
   logic [WIDTH-1:0] b_cmp;
   logic [CHUNK-1:0] a_chunks [SLOTS];
   logic [CHUNK-1:0] b_chunks [SLOTS];
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;

   // Signed compare: flipping the sign bit maps two's-complement order onto
   // unsigned order, so the chunk compare below stays purely unsigned.
   always_comb begin
      a_cmp = a_reg;
      b_cmp = b_reg;
      if (mode_reg) begin
         a_cmp[WIDTH-1] = ~a_reg[WIDTH-1];
         b_cmp[WIDTH-1] = ~b_reg[WIDTH-1];
      end
   end

   // Slice both operands into chunks, slot 0 holding the most significant
   // chunk; unused slots (N not a power of two) are tied off.
   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_chunk
         if (gi < N) begin : g_used
            assign a_chunks[gi] = a_cmp[WIDTH-1-gi*CHUNK -: CHUNK];
            assign b_chunks[gi] = b_cmp[WIDTH-1-gi*CHUNK -: CHUNK];
         end else begin : g_unused
            assign a_chunks[gi] = '0;
            assign b_chunks[gi] = '0;
         end
      end
   endgenerate

   assign a_chunk = a_chunks[idx_reg];
   assign b_chunk = b_chunks[idx_reg];

   // Control FSM with registered status and result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         mode_reg  <= 1'b0;
         idx_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         eq_reg    <= 1'b0;
         lt_reg    <= 1'b0;
         gt_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  mode_reg  <= signed_mode & (SIGNED_EN != 0);
                  idx_reg   <= '0;
                  eq_reg    <= 1'b0;
                  lt_reg    <= 1'b0;
                  gt_reg    <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               if (a_chunk != b_chunk) begin
                  lt_reg    <= (a_chunk < b_chunk);
                  gt_reg    <= (a_chunk > b_chunk);
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (idx_reg == LAST_IDX) begin
                  eq_reg    <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign eq   = eq_reg;
   assign lt   = lt_reg;
   assign gt   = gt_reg;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three instances (bit-serial signed,
// nibble-serial signed, bit-serial with signed support disabled) driven by
// directed and random operations, checked against an arithmetic model.
module tb_serial_magnitude_comparator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       signed_mode;
   logic [2:0] start_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] eq_v;
   logic [2:0] lt_v;
   logic [2:0] gt_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(8), .CHUNK(1), .SIGNED_EN(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
      .eq(eq_v[0]), .lt(lt_v[0]), .gt(gt_v[0]));

   serial_magnitude_comparator #(.WIDTH(8), .CHUNK(4), .SIGNED_EN(1)) u_c4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
      .eq(eq_v[1]), .lt(lt_v[1]), .gt(gt_v[1]));

   serial_magnitude_comparator #(.WIDTH(8), .CHUNK(1), .SIGNED_EN(0)) u_ns (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]),
      .eq(eq_v[2]), .lt(lt_v[2]), .gt(gt_v[2]));

   // Reference: result from integer arithmetic, latency from the index of
   // the first differing chunk counted from the top of the word.
   function automatic void model(input int inst, input logic [7:0] av, input logic [7:0] bv,
                                 input bit sm, output int lat, output logic e,
                                 output logic l, output logic g);
      int c, n, sa, sb, ca, cb;
      bit sgn;
      c   = (inst == 1) ? 4 : 1;
      n   = 8 / c;
      sgn = sm && (inst != 2);
      lat = n;
      for (int i = 0; i < n; i++) begin
         ca = (int'(av) >> (8 - (i + 1) * c)) & ((1 << c) - 1);
         cb = (int'(bv) >> (8 - (i + 1) * c)) & ((1 << c) - 1);
         if (ca != cb) begin
            lat = i + 1;
            break;
         end
      end
      sa = int'(av);
      sb = int'(bv);
      if (sgn) begin
         if (sa >= 128) sa = sa - 256;
         if (sb >= 128) sb = sb - 256;
      end
      e = (sa == sb);
      l = (sa < sb);
      g = (sa > sb);
   endfunction

   // One full operation on one instance; drives immediately (caller ensures
   // we are between clock edges, possibly inside the previous DONE cycle).
   task automatic do_compare(input int inst, input logic [7:0] av, input logic [7:0] bv,
                             input bit sm, input string name);
      int   lat, cyc;
      logic e, l, g;
      bit   seen;
      model(inst, av, bv, sm, lat, e, l, g);
      a = av;
      b = bv;
      signed_mode = sm;
      start_v[inst] = 1'b1;
      @(posedge clk);
      #1;
      start_v[inst] = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      signed_mode = 1'($urandom);
      checks++;
      if (busy_v[inst] !== 1'b1 || done_v[inst] !== 1'b0 ||
          {eq_v[inst], lt_v[inst], gt_v[inst]} !== 3'b000) begin
         errors++;
         $display("FAIL accept_%s: busy=%b done=%b eqltgt=%b%b%b, expected busy=1 done=0 eqltgt=000",
                  name, busy_v[inst], done_v[inst], eq_v[inst], lt_v[inst], gt_v[inst]);
      end
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done_v[inst] === 1'b1) begin
            seen = 1;
         end else begin
            checks++;
            if (busy_v[inst] !== 1'b1) begin
               errors++;
               $display("FAIL busy_%s: busy=%b at cycle %0d, expected 1", name, busy_v[inst], cyc);
            end
         end
      end
      checks++;
      if (!seen || cyc != lat || busy_v[inst] !== 1'b0 ||
          eq_v[inst] !== e || lt_v[inst] !== l || gt_v[inst] !== g) begin
         errors++;
         $display("FAIL result_%s: got eqltgt=%b%b%b busy=%b lat=%0d (done seen=%0d), expected eqltgt=%b%b%b busy=0 lat=%0d",
                  name, eq_v[inst], lt_v[inst], gt_v[inst], busy_v[inst], cyc, seen, e, l, g, lat);
      end
      $display("op %s inst=%0d a=%02h b=%02h signed=%0d -> eq=%b lt=%b gt=%b latency=%0d",
               name, inst, av, bv, sm, eq_v[inst], lt_v[inst], gt_v[inst], cyc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_v = 3'b000;
      a = 8'h00;
      b = 8'h00;
      signed_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_v, done_v, eq_v, lt_v, gt_v} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: outputs=%b, expected all 0", {busy_v, done_v, eq_v, lt_v, gt_v});
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released");
      @(negedge clk);
   endtask

   task automatic test_directed();
      do_compare(0, 8'hF0, 8'h0F, 1'b0, "unsigned_f0_0f");
      @(negedge clk);
      do_compare(0, 8'hF0, 8'h0F, 1'b1, "signed_f0_0f");
      @(negedge clk);
      do_compare(2, 8'hF0, 8'h0F, 1'b1, "signed_disabled_f0_0f");
      @(negedge clk);
      do_compare(0, 8'h5A, 8'h5A, 1'b0, "equal_5a");
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (eq_v[0] !== 1'b1 || lt_v[0] !== 1'b0 || gt_v[0] !== 1'b0 ||
          done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_equal: eqltgt=%b%b%b done=%b busy=%b, expected eqltgt=100 done=0 busy=0",
                  eq_v[0], lt_v[0], gt_v[0], done_v[0], busy_v[0]);
      end
      $display("hold after 3 idle cycles: eq=%b lt=%b gt=%b", eq_v[0], lt_v[0], gt_v[0]);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      do_compare(1, 8'h35, 8'h3A, 1'b0, "nibble_35_3a");
      // Still inside the DONE cycle here: the next start must be taken.
      do_compare(1, 8'h80, 8'h7F, 1'b0, "b2b_80_7f");
   endtask

   task automatic test_start_ignored();
      int  cyc;
      bit  seen;
      @(negedge clk);
      a = 8'h01;
      b = 8'h00;
      signed_mode = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 3) begin
            a = 8'h00;
            b = 8'h00;
            start_v[0] = 1'b1;
         end else begin
            start_v[0] = 1'b0;
         end
         if (done_v[0] === 1'b1) seen = 1;
      end
      start_v[0] = 1'b0;
      checks++;
      if (!seen || cyc != 8 || gt_v[0] !== 1'b1 || eq_v[0] !== 1'b0 || lt_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL start_in_run: got eqltgt=%b%b%b lat=%0d, expected eqltgt=001 lat=8",
                  eq_v[0], lt_v[0], gt_v[0], cyc);
      end
      $display("op start_in_run a=01 b=00 -> eq=%b lt=%b gt=%b latency=%0d", eq_v[0], lt_v[0], gt_v[0], cyc);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a = 8'hFF;
      b = 8'hFF;
      signed_mode = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_run: busy/done/eq/lt/gt=%b, expected 00000",
                  {busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_held: busy/done/eq/lt/gt=%b, expected 00000",
                  {busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]});
      end
      $display("reset mid-run: outputs cleared");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_compare(0, 8'h00, 8'h01, 1'b0, "after_reset_00_01");
   endtask

   task automatic test_random();
      int         inst, gap, kind;
      logic [7:0] av, bv;
      for (int n = 0; n < 90; n++) begin
         inst = int'($urandom_range(0, 2));
         gap  = int'($urandom_range(0, 2));
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         av   = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         if (kind == 0)      bv = av;
         else if (kind == 1) bv = av ^ (8'h01 << $urandom_range(0, 7));
         else                bv = 8'($urandom);
         do_compare(inst, av, bv, 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
